uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master side is the requesters plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_byte;
  logic              tx_load;
  logic              tx_start;
  logic              tx_busy;
  logic [GW-1:0]     grant_id;
  logic              timeout_err;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_byte, tx_load, tx_start, grant_id, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_byte, tx_load, tx_start, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter handing one byte per frame to a UART transmitter.
// Optional packet lock (keep the grantee until req_last): define UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LIMIT = CW'(START_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant_id;
  logic [7:0]      r_tx_byte;
  logic            r_tx_load;
  logic            r_tx_start;
  logic            r_timeout_err;
  logic [CW-1:0]   r_cnt;
`ifdef UART_ARB_PKT_LOCK_EN
  logic            r_lock;
`endif

  int              w_idx;
  logic            w_rr_found;
  logic [GW-1:0]   w_rr_pick;
  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic [NREQ-1:0] w_onehot;
  logic [7:0]      w_sel_data;

  // Round-robin search starting just after the most recent grantee.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = r_grant_id;
    w_idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_grant_id) + k) % NREQ;
      if (!w_rr_found && bus.req_valid[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = GW'(w_idx);
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  // Final grant choice; a held packet lock pins the grant to the current owner.
  always_comb begin
    w_found = w_rr_found;
    w_pick  = w_rr_pick;
`ifdef UART_ARB_PKT_LOCK_EN
    if (r_lock) begin
      w_found = bus.req_valid[r_grant_id];
      w_pick  = r_grant_id;
    end else begin
      w_found = w_rr_found;
      w_pick  = w_rr_pick;
    end
`endif
  end

  // Accept pulse is issued in the IDLE cycle itself so the requester sees a normal valid/ready beat.
  always_comb begin
    w_onehot         = {NREQ{1'b0}};
    w_onehot[w_pick] = 1'b1;
    w_sel_data       = bus.req_data[{w_pick, 3'b000} +: 8];
  end

  // Arbitration and frame sequencing FSM with registered pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant_id    <= GW'(NREQ - 1);
      r_tx_byte     <= 8'hFF;
      r_tx_load     <= 1'b0;
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= {CW{1'b0}};
`ifdef UART_ARB_PKT_LOCK_EN
      r_lock        <= 1'b0;
`endif
    end else begin
      r_tx_load     <= 1'b0;
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_tx_byte  <= w_sel_data;
            r_tx_load  <= 1'b1;
            r_state    <= LOAD;
`ifdef UART_ARB_PKT_LOCK_EN
            r_lock     <= ~bus.req_last[w_pick];
`endif
          end
        end
        LOAD: begin
          r_tx_start <= 1'b1;
          r_state    <= START;
        end
        START: begin
          r_cnt   <= {CW{1'b0}};
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == TMO_LIMIT) begin
            // Transmitter never answered: drop the byte and free the bus.
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
            r_lock        <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1'b1);
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = (r_state == IDLE && w_found && !reset) ? w_onehot : {NREQ{1'b0}};
  assign bus.tx_byte     = r_tx_byte;
  assign bus.tx_load     = r_tx_load;
  assign bus.tx_start    = r_tx_start;
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: grant-order table, hand-written latency/timeout/reset/packet
// sequences, then random traffic scored every cycle by a timestamp-based reference model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 255;
`ifdef UART_ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();
  uart_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [NREQ-1:0] valid;
    int              gid;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // requester stimulus and transmitter model
  logic [NREQ-1:0] sv, sl;
  logic [7:0]      sd [NREQ];
  int bus_on, bus_off, nx_d, nx_L;
  bit rnd_tx, glitch_en;

  // reference model: frame timing expressed as absolute cycle stamps
  int m_free, m_load, m_start, m_tmo, m_last, m_sel, exp_gid;
  bit m_lock;
  logic [7:0] exp_byte, m_sel_byte;

  // sampled outputs
  logic [NREQ-1:0] o_ready;
  logic o_load, o_start, o_tmo;
  logic [7:0] o_byte;
  logic [1:0] o_gid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_free   = 0;
    m_load   = -1;
    m_start  = -1;
    m_tmo    = -1;
    m_last   = NREQ - 1;
    m_sel    = NREQ - 1;
    exp_gid  = NREQ - 1;
    exp_byte = 8'hFF;
    m_lock   = 1'b0;
    bus_on   = 0;
    bus_off  = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sv = '0;
    bus.req_valid = '0;
    bus.tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // one clock: drive inputs, predict outputs, sample mid-cycle, compare
  task automatic tick();
    logic [NREQ-1:0] e_ready;
    bit e_load, e_start, e_tmo;
    int sel;
    @(posedge clk);
    #1;
    cyc++;
    bus.req_valid = sv;
    bus.req_last  = sl;
    for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = sd[i];
    bus.tx_busy = (cyc >= bus_on && cyc < bus_off) ||
                  (glitch_en && (cyc >= m_free || cyc == m_load || cyc == m_start) &&
                   $urandom_range(0, 3) == 0);
    e_load  = (cyc == m_load);
    e_start = (cyc == m_start);
    e_tmo   = (cyc == m_tmo);
    if (e_load) begin
      exp_gid  = m_sel;
      exp_byte = m_sel_byte;
    end
    e_ready = '0;
    sel = -1;
    if (cyc >= m_free) sel = m_lock ? (sv[m_last] ? m_last : -1) : rr_pick(sv, m_last);
    if (sel >= 0) begin
      e_ready[sel] = 1'b1;
      m_sel      = sel;
      m_sel_byte = sd[sel];
      m_load     = cyc + 1;
      m_start    = cyc + 2;
      if (nx_L == 0) begin
        m_tmo  = cyc + 3 + TMO + 1;
        m_free = m_tmo;
        m_lock = 1'b0;
      end else begin
        m_free = cyc + 2 + nx_d + nx_L + 1;
        m_lock = LOCK_EN && !bus.req_last[sel];
      end
      m_last = sel;
    end
    @(negedge clk);
    o_ready = bus.req_ready;
    o_load  = bus.tx_load;
    o_start = bus.tx_start;
    o_tmo   = bus.timeout_err;
    o_byte  = bus.tx_byte;
    o_gid   = bus.grant_id;
    chk("req_ready",   32'(o_ready), 32'(e_ready));
    chk("tx_load",     32'(o_load),  32'(e_load));
    chk("tx_start",    32'(o_start), 32'(e_start));
    chk("timeout_err", 32'(o_tmo),   32'(e_tmo));
    chk("tx_byte",     32'(o_byte),  32'(exp_byte));
    chk("grant_id",    32'(o_gid),   32'(exp_gid));
    if (o_start) begin
      bus_on  = cyc + nx_d;
      bus_off = bus_on + nx_L;
      if (rnd_tx) begin
        nx_d = int'($urandom_range(1, 3));
        nx_L = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12));
      end
    end
  endtask

  task automatic wait_ready(input int bound, output int idx);
    idx = -1;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (o_ready != '0) begin
        idx = onehot_idx(o_ready);
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    int   idx, t0, got;
    int   exp_e [5];
    int   c2;

    tbl[0]  = '{4'b1111, 0};
    tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b1111, 2};
    tbl[3]  = '{4'b1111, 3};
    tbl[4]  = '{4'b1111, 0};
    tbl[5]  = '{4'b1010, 1};
    tbl[6]  = '{4'b1010, 3};
    tbl[7]  = '{4'b1010, 1};
    tbl[8]  = '{4'b1001, 3};
    tbl[9]  = '{4'b1001, 0};
    tbl[10] = '{4'b0100, 2};
    tbl[11] = '{4'b0001, 0};
`ifdef UART_ARB_PKT_LOCK_EN
    exp_e = '{2, 2, 2, 0, 0};
`else
    exp_e = '{2, 0, 2, 0, 2};
`endif

    rnd_tx = 1'b0;
    glitch_en = 1'b0;
    sl = '1;
    for (int i = 0; i < NREQ; i++) sd[i] = 8'h00;
    bus.req_data = '0;
    bus.req_last = '1;
    do_reset();

    // reset state
    chk("rst_tx_byte",  32'(bus.tx_byte), 32'h0000_00FF);
    chk("rst_grant_id", 32'(bus.grant_id), 32'(NREQ - 1));
    chk("rst_pulses",   32'({bus.tx_load, bus.tx_start, bus.timeout_err}), 32'h0);
    chk("rst_ready",    32'(bus.req_ready), 32'h0);

    // single requester latency: busy 2 cycles after start for 10 cycles
    nx_d = 2; nx_L = 10;
    sv = 4'b0010; sd[1] = 8'hA5; sl = '1;
    wait_ready(20, idx);
    chk("lat_accept_req1", 32'(o_ready), 32'h2);
    t0 = cyc;
    sd[1] = 8'h5A;
    tick();
    chk("lat_load_T1", 32'(o_load), 32'h1);
    chk("lat_byte_A5", 32'(o_byte), 32'h0000_00A5);
    tick();
    chk("lat_start_T2", 32'(o_start), 32'h1);
    wait_ready(30, idx);
    chk("lat_next_accept_gap", 32'(cyc - t0), 32'd15);
    sv = '0;
    repeat (20) tick();

    // round-robin order table
    do_reset();
    nx_d = 1; nx_L = 1;
    for (int r = 0; r < 12; r++) begin
      sv = tbl[r].valid;
      for (int i = 0; i < NREQ; i++) sd[i] = 8'($urandom);
      wait_ready(40, idx);
      chk("rr_grant", 32'(idx), 32'(tbl[r].gid));
    end
    sv = '0;
    repeat (10) tick();

    // start timeout: transmitter never raises busy
    nx_d = 1; nx_L = 0;
    sv = 4'b0110;
    wait_ready(20, idx);
    chk("tmo_first_grant", 32'(idx), 32'd1);
    t0 = cyc;
    sv = 4'b0100;
    tick();
    tick();
    nx_L = 1;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (o_tmo) begin
        got = 1;
        break;
      end
    end
    chk("tmo_seen", 32'(got), 32'h1);
    chk("tmo_delay", 32'(cyc - t0), 32'd259);
    chk("tmo_next_served", 32'(o_ready), 32'h4);
    sv = '0;
    tick();
    chk("tmo_one_cycle", 32'(o_tmo), 32'h0);
    repeat (10) tick();

    // reset while in WAIT_DONE
    nx_d = 1; nx_L = 20;
    sv = 4'b1000;
    wait_ready(20, idx);
    chk("rst_mid_grant", 32'(idx), 32'd3);
    sv = '0;
    repeat (8) tick();
    bus.req_valid = '1;
    reset = 1'b1;
    #1;
    chk("rst_mid_tx_byte", 32'(bus.tx_byte), 32'h0000_00FF);
    chk("rst_mid_pulses",  32'({bus.tx_load, bus.tx_start, bus.timeout_err}), 32'h0);
    chk("rst_mid_ready",   32'(bus.req_ready), 32'h0);
    chk("rst_mid_gid",     32'(bus.grant_id), 32'(NREQ - 1));
    do_reset();
    nx_L = 1;
    sv = '1; sl = '1;
    wait_ready(20, idx);
    chk("rst_mid_next_grant", 32'(idx), 32'd0);
    sv = '0;
    repeat (10) tick();

    // packet of three bytes from requester 2 while requester 0 stays valid
    c2 = 0;
    sv = 4'b0101; sl = 4'b1011; sd[0] = 8'h01; sd[2] = 8'h20;
    got = 0;
    for (int k = 0; k < 200 && got < 5; k++) begin
      tick();
      if (o_ready != '0) begin
        idx = onehot_idx(o_ready);
        chk("pkt_order", 32'(idx), 32'(exp_e[got]));
        got++;
        if (idx == 2) begin
          c2++;
          if (c2 < 3) begin
            sd[2] = 8'h20 + 8'(c2);
            sl[2] = (c2 == 2);
          end else begin
            sv[2] = 1'b0;
          end
        end else begin
          sd[0] = sd[0] + 8'h01;
        end
      end
    end
    chk("pkt_count", 32'(got), 32'd5);
    sv = '0; sl = '1;
    repeat (10) tick();

    // random traffic against the reference model
    rnd_tx = 1'b1;
    glitch_en = 1'b1;
    nx_d = 1; nx_L = 3;
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!sv[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            sv[i] = 1'b1;
            sd[i] = 8'($urandom);
            sl[i] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 39) == 0) begin
          sv[i] = 1'b0;
        end
      end
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (o_ready[i]) sv[i] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
